// File: rtl/rv_muldiv_sequencer.sv
// rtl/rv_muldiv_sequencer.sv - iterative RV32M multiply/divide execution unit
//
// Accepts one RV32M command at a time and runs it on a shared shift-add /
// restoring-divide datapath, retiring BITS_PER_CYCLE bits per ITER cycle.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous kill of any in-flight or held operation
//   cmd_valid/ready   command handshake; cmd_ready only in IDLE without flush
//   cmd_funct3        RV32M funct3 (MUL..REMU)
//   cmd_a, cmd_b      rs1 / rs2 operands
//   cmd_tag           opaque tag returned with the result
//   res_valid/ready   result handshake; res_data/res_tag held while stalled
//   res_data, res_tag 32-bit result and the tag of its command

module rv_muldiv_sequencer #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_WIDTH      = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_funct3,
    input  logic [31:0]          cmd_a,
    input  logic [31:0]          cmd_b,
    input  logic [TAG_WIDTH-1:0] cmd_tag,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic [TAG_WIDTH-1:0] res_tag
);

    localparam int ITER  = 32 / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ITER,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [31:0]            a_q, a_d;
    logic [31:0]            b_q, b_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic                   neg_a_q, neg_a_d;
    logic                   neg_b_q, neg_b_d;
    // Multiply: {high, low} with the multiplier in low, shifted right.
    // Divide:   {remainder, dividend/quotient}, shifted left.
    logic [63:0]            acc_q, acc_d;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [31:0]            opnd_q, opnd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            res_data_q, res_data_d;
    logic [TAG_WIDTH-1:0]   res_tag_q, res_tag_d;

    // Operation decode from the registered funct3.
    logic is_div, is_rem, signed_a, signed_b, div_signed;
    assign is_div     = funct3_q[2];
    assign is_rem     = funct3_q[2] & funct3_q[1];
    assign div_signed = funct3_q[2] & ~funct3_q[0];
    assign signed_a   = (funct3_q == 3'b001) | (funct3_q == 3'b010) | div_signed;
    assign signed_b   = (funct3_q == 3'b001) | div_signed;

    assign cmd_ready = (state_q == S_IDLE) && !flush;
    assign res_valid = (state_q == S_DONE);
    assign res_data  = res_data_q;
    assign res_tag   = res_tag_q;

    // One ITER cycle worth of datapath steps.
    logic [63:0] step_acc;
    logic [32:0] sum;
    logic [32:0] top;
    always_comb begin
        step_acc = acc_q;
        sum      = '0;
        top      = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (!is_div) begin
                sum      = {1'b0, step_acc[63:32]} + (step_acc[0] ? {1'b0, opnd_q} : 33'd0);
                step_acc = {sum, step_acc[31:1]};
            end else begin
                // Shifted partial remainder can reach 33 bits before the trial subtract.
                top = step_acc[63:31];
                if (top >= {1'b0, opnd_q}) begin
                    top      = top - {1'b0, opnd_q};
                    step_acc = {top[31:0], step_acc[30:0], 1'b1};
                end else begin
                    step_acc = {top[31:0], step_acc[30:0], 1'b0};
                end
            end
        end
    end

    // Sign correction and word selection.
    logic [63:0] prod;
    logic [31:0] quo, rem, fix_res;
    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? (~acc_q + 64'd1) : acc_q;
        quo  = (neg_a_q ^ neg_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem  = neg_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        if (!is_div) begin
            fix_res = (funct3_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
        end else begin
            fix_res = is_rem ? rem : quo;
        end
    end

    // Special-case detection on the registered operands.
    logic        div_by_zero, div_ovf;
    logic [31:0] mag_a, mag_b;
    logic        sa_neg, sb_neg;
    always_comb begin
        div_by_zero = is_div && (b_q == 32'd0);
        div_ovf     = div_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        sa_neg      = signed_a & a_q[31];
        sb_neg      = signed_b & b_q[31];
        mag_a       = sa_neg ? (~a_q + 32'd1) : a_q;
        mag_b       = sb_neg ? (~b_q + 32'd1) : b_q;
    end

    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        a_d        = a_q;
        b_d        = b_q;
        tag_d      = tag_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_tag_d  = res_tag_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    funct3_d = cmd_funct3;
                    a_d      = cmd_a;
                    b_d      = cmd_b;
                    tag_d    = cmd_tag;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                neg_a_d = sa_neg;
                neg_b_d = sb_neg;
                acc_d   = {32'd0, is_div ? mag_a : mag_b};
                opnd_d  = is_div ? mag_b : mag_a;
                cnt_d   = CNT_W'(ITER - 1);
                if (div_by_zero) begin
                    res_data_d = is_rem ? a_q : 32'hFFFF_FFFF;
                    res_tag_d  = tag_q;
                    state_d    = S_DONE;
                end else if (div_ovf) begin
                    res_data_d = is_rem ? 32'd0 : 32'h8000_0000;
                    res_tag_d  = tag_q;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                res_data_d = fix_res;
                res_tag_d  = tag_q;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A killed op must never publish its result, even into the held registers.
        if (flush) begin
            state_d    = S_IDLE;
            res_data_d = res_data_q;
            res_tag_d  = res_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            funct3_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            acc_q      <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            a_q        <= a_d;
            b_q        <= b_d;
            tag_q      <= tag_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_tag_q  <= res_tag_d;
        end
    end

endmodule

// File: tb/tb_rv_muldiv_sequencer.sv
// tb/tb_rv_muldiv_sequencer.sv - self-checking bench for rv_muldiv_sequencer

module tb_rv_muldiv_sequencer;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [1:0]  cmd_valid;
    logic [1:0]  cmd_ready;
    logic [2:0]  cmd_funct3 [2];
    logic [31:0] cmd_a      [2];
    logic [31:0] cmd_b      [2];
    logic [4:0]  cmd_tag    [2];
    logic [1:0]  res_valid;
    logic [1:0]  res_ready;
    logic [31:0] res_data   [2];
    logic [4:0]  res_tag    [2];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sbq[$];
    vec_t vecs[12];
    bit   prev_v [2];
    int   vstart [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rv_muldiv_sequencer #(.BITS_PER_CYCLE(1), .TAG_WIDTH(5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_funct3(cmd_funct3[0]),
        .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_tag(cmd_tag[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_data(res_data[0]), .res_tag(res_tag[0])
    );

    rv_muldiv_sequencer #(.BITS_PER_CYCLE(4), .TAG_WIDTH(5)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_funct3(cmd_funct3[1]),
        .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_tag(cmd_tag[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_data(res_data[1]), .res_tag(res_tag[1])
    );

    function automatic int iter_of(input int u);
        return (u == 0) ? 32 : 8;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every delivered result pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int u = 0; u < 2; u++) begin
            if (res_valid[u] && !prev_v[u]) vstart[u] = cyc;
            if (res_valid[u] && res_ready[u] && rst_n && !flush) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result unit%0d: got data 0x%08h tag %0d, required none",
                             u, res_data[u], res_tag[u]);
                end else begin
                    e = sbq.pop_front();
                    check("res_data", res_data[u], e.data);
                    check("res_tag", 32'(res_tag[u]), 32'(e.tag));
                    check("latency", 32'(vstart[u] - e.acc_cyc), 32'(e.lat));
                end
            end
            prev_v[u] = res_valid[u];
        end
    end

    task automatic issue(input int u, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp, input bit special, input bit push);
        int   n;
        exp_t e;
        @(posedge clk);
        #1;
        cmd_valid[u]  = 1'b1;
        cmd_funct3[u] = f;
        cmd_a[u]      = a;
        cmd_b[u]      = b;
        cmd_tag[u]    = tag;
        n = 0;
        @(negedge clk);
        while (!cmd_ready[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready[u]) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout unit%0d: cmd_ready got 0, required 1", u);
        end else if (push) begin
            e.data    = exp;
            e.tag     = tag;
            e.lat     = special ? 2 : iter_of(u) + 3;
            e.acc_cyc = cyc;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid[u] = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sbq.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL result_timeout: got %0d pending results, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        int  k;
        bit  seen;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 1'b0};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 1'b0};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{3'b101, 32'd100,       32'd7,         5'd7,  32'd14,        1'b0};
        vecs[7]  = '{3'b111, 32'd100,       32'd7,         5'd8,  32'd2,         1'b0};
        vecs[8]  = '{3'b101, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{3'b111, 32'd5,         32'd0,         5'd10, 32'd5,         1'b1};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1'b1};

        rst_n     = 1'b0;
        flush     = 1'b0;
        cmd_valid = 2'b00;
        res_ready = 2'b11;
        for (int u = 0; u < 2; u++) begin
            cmd_funct3[u] = '0;
            cmd_a[u]      = '0;
            cmd_b[u]      = '0;
            cmd_tag[u]    = '0;
        end

        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset_cmd_ready", 32'(cmd_ready[u]), 32'd1);
            check("reset_res_valid", 32'(res_valid[u]), 32'd0);
            check("reset_res_data", res_data[u], 32'd0);
            check("reset_res_tag", 32'(res_tag[u]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 12; i++) begin
                issue(u, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].tag,
                      vecs[i].exp, vecs[i].special, 1'b1);
                wait_empty();
            end

            // Backpressure: result held while res_ready is low.
            res_ready[u] = 1'b0;
            issue(u, 3'b101, 32'd100, 32'd7, 5'd15, 32'd14, 1'b0, 1'b1);
            n = 0;
            while (!res_valid[u] && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("bp_valid_seen", 32'(res_valid[u]), 32'd1);
            for (int i = 0; i < 10; i++) begin
                check("bp_hold_data", res_data[u], 32'd14);
                check("bp_hold_tag", 32'(res_tag[u]), 32'd15);
                check("bp_cmd_ready_low", 32'(cmd_ready[u]), 32'd0);
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            res_ready[u] = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check("bp_cmd_ready_after", 32'(cmd_ready[u]), 32'd1);
            check("bp_valid_after", 32'(res_valid[u]), 32'd0);
            wait_empty();

            // Flush mid-ITER of a DIV: no result ever appears.
            k = (iter_of(u) > 10) ? 10 : 4;
            issue(u, 3'b100, 32'd1000000, 32'd7, 5'd20, 32'd0, 1'b0, 1'b0);
            repeat (k) @(posedge clk);
            #1;
            flush = 1'b1;
            @(negedge clk);
            check("flush_cmd_ready_gated", 32'(cmd_ready[u]), 32'd0);
            @(posedge clk);
            #1;
            flush = 1'b0;
            @(negedge clk);
            check("flush_cmd_ready_next", 32'(cmd_ready[u]), 32'd1);
            seen = 1'b0;
            repeat (iter_of(u) + 10) begin
                if (res_valid[u]) seen = 1'b1;
                @(negedge clk);
            end
            check("flush_no_result", 32'(seen), 32'd0);
            issue(u, 3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 1'b0, 1'b1);
            wait_empty();

            // Asynchronous reset mid-ITER.
            issue(u, 3'b100, 32'd1000, 32'd3, 5'd22, 32'd0, 1'b0, 1'b0);
            repeat (4) @(posedge clk);
            #3;
            rst_n = 1'b0;
            #1;
            check("areset_res_valid", 32'(res_valid[u]), 32'd0);
            check("areset_cmd_ready", 32'(cmd_ready[u]), 32'd1);
            check("areset_res_data", res_data[u], 32'd0);
            #3;
            rst_n = 1'b1;
            issue(u, 3'b000, 32'd3, 32'd4, 5'd23, 32'd12, 1'b0, 1'b1);
            wait_empty();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
